// File: rtl/fpu_seq.sv
// Issue/sequencing controller between FP decode and the FPU datapath: single-cycle ops
// retire one per cycle, fdiv/fsqrt run on a shared multi-cycle unit under a watchdog.
module fpu_seq #(
  parameter int BUS_WIDTH  = 64,
  parameter int FPU_OP_LEN = 6,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FPU_OP_LEN-1:0] fpu_op,
  input  logic                  fpu_rd,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [BUS_WIDTH-1:0]  comb_result,
  output logic                  mc_start,
  output logic [1:0]            mc_op,
  input  logic                  mc_done,
  input  logic [BUS_WIDTH-1:0]  mc_result,
  output logic                  mc_abort,
  output logic                  wb_valid,
  output logic                  wb_fp,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [BUS_WIDTH-1:0]  wb_data,
  output logic                  stall,
  output logic                  illegal,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mc_start_q, mc_abort_q, wb_valid_q, wb_fp_q, illegal_q, timeout_q;
  logic [1:0]            mc_op_q;
  logic [REG_ADDR_W-1:0] wb_addr_q, mc_rd_q;
  logic                  mc_fp_q;
  logic [BUS_WIDTH-1:0]  wb_data_q;
  logic                  is_mc_d, is_sc_d, accept_d;

  always_comb begin
    is_mc_d = (fpu_op >= FPU_OP_LEN'(6)) && (fpu_op <= FPU_OP_LEN'(9));
    is_sc_d = (fpu_op <= FPU_OP_LEN'(5)) ||
              ((fpu_op >= FPU_OP_LEN'(16)) && (fpu_op <= FPU_OP_LEN'(33)));
  end

  // Ready is forced low during reset so nothing is accepted while the FSM is being cleared.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept_d  = req_valid && req_ready;
  assign stall     = req_valid && !req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mc_start_q <= 1'b0;
      mc_abort_q <= 1'b0;
      mc_op_q    <= 2'b00;
      wb_valid_q <= 1'b0;
      wb_fp_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      mc_rd_q    <= '0;
      mc_fp_q    <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      mc_start_q <= 1'b0;
      mc_abort_q <= 1'b0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            if (is_mc_d) begin
              mc_rd_q    <= rd_addr;
              mc_fp_q    <= fpu_rd;
              mc_op_q    <= {fpu_op[3], fpu_op[0]};
              mc_start_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_ISSUE;
            end else if (is_sc_d) begin
              wb_valid_q <= 1'b1;
              wb_fp_q    <= fpu_rd;
              wb_addr_q  <= rd_addr;
              wb_data_q  <= comb_result;
            end else begin
              illegal_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Count the issue cycle so the abort lands exactly TIMEOUT cycles after mc_start.
          cnt_q   <= cnt_q + 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mc_done) begin
            wb_valid_q <= 1'b1;
            wb_fp_q    <= mc_fp_q;
            wb_addr_q  <= mc_rd_q;
            wb_data_q  <= mc_result;
            state_q    <= S_WB;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mc_abort_q <= 1'b1;
            timeout_q  <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mc_start    = mc_start_q;
  assign mc_op       = mc_op_q;
  assign mc_abort    = mc_abort_q;
  assign wb_valid    = wb_valid_q;
  assign wb_fp       = wb_fp_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;
  assign timeout_err = timeout_q;

endmodule
